// File: rtl/ysyx_23060203_mem_resp.sv
// rtl/ysyx_23060203_mem_resp.sv - load/store responder with RV32 sizing and configurable latency
// Optional: YSYX_23060203_MEM_LFSR_DELAY_EN adds an LFSR-driven extra delay of 0..3 cycles per request.
// Timing: accept at edge T, memory access at edge T+1+delay, rsp_valid high from that edge.
module ysyx_23060203_mem_resp #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic        l_wen;
    logic [2:0]  l_func;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [8:0]  cnt;
    logic [8:0]  accept_delay;

    logic [31:0] mem [DEPTH];

    logic [31:0] widx;
    logic [IW-1:0] idx;
    logic        in_range;
    logic        misalign;
    logic        illegal;
    logic        acc_err;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        do_access;

    // Ready is purely a function of state; held low while reset is asserted.
    assign req_ready = (state == S_IDLE) && !rst;
    assign do_access = (state == S_WAIT) && (cnt == 9'd0);

`ifdef YSYX_23060203_MEM_LFSR_DELAY_EN
    logic [7:0] lfsr;

    assign accept_delay = 9'(LATENCY) + {7'd0, lfsr[1:0]};

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (state == S_IDLE && req_valid) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign accept_delay = 9'(LATENCY);
`endif

    // Decode the latched request: range, alignment, legality, read data and store merge.
    always_comb begin
        widx     = (l_addr - BASE) >> 2;
        in_range = (l_addr >= BASE) && (widx < 32'(DEPTH));
        idx      = widx[IW-1:0];
        case (l_func[1:0])
            2'b01:   misalign = l_addr[0];
            2'b10:   misalign = |l_addr[1:0];
            default: misalign = 1'b0;
        endcase
        if (l_wen) illegal = l_func[2] || (l_func[1:0] == 2'b11);
        else       illegal = (l_func == 3'b011) || (l_func[2:1] == 2'b11);
        acc_err = !in_range || misalign || illegal;

        word    = mem[idx];
        shifted = word >> {l_addr[1:0], 3'b000};
        case (l_func)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            3'b010:  load_val = shifted;
            default: load_val = 32'd0;
        endcase

        merged = word;
        case (l_func[1:0])
            2'b00:   merged[{l_addr[1:0], 3'b000} +: 8]  = l_wdata[7:0];
            2'b01:   merged[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
            2'b10:   merged = l_wdata;
            default: merged = word;
        endcase
    end

    // Request/response sequencer: latch on accept, count down, access, hold response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 9'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            l_wen     <= 1'b0;
            l_func    <= 3'd0;
            l_addr    <= 32'd0;
            l_wdata   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        l_wen   <= req_wen;
                        l_func  <= req_func;
                        l_addr  <= req_addr;
                        l_wdata <= req_wdata;
                        cnt     <= accept_delay;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 9'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || l_wen) ? 32'd0 : load_val;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Store commit happens only on the access edge; a reset on that edge discards it.
    always_ff @(posedge clk) begin
        if (!rst && do_access && l_wen && !acc_err) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_mem_resp.sv
// tb/tb_ysyx_23060203_mem_resp.sv - randomized bench with byte-level reference model for ysyx_23060203_mem_resp
module tb_ysyx_23060203_mem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
`ifdef YSYX_23060203_MEM_LFSR_DELAY_EN
    localparam int FIRST_LAT = LAT + 2;
`else
    localparam int FIRST_LAT = LAT + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_func = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    ysyx_23060203_mem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference memory kept as bytes; little-endian assembly on loads.
    logic [7:0] mb [DEPTH*4];

    function automatic int size_of(input logic [2:0] f);
        return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic void model_eval(input logic wen, input logic [2:0] f, input logic [31:0] a,
                                       output logic [31:0] rd, output logic err);
        int sz;
        logic legal, inr, algn;
        logic [63:0] v;
        int rel;
        sz    = size_of(f);
        legal = wen ? (f <= 3'd2) : !(f == 3'd3 || f == 3'd6 || f == 3'd7);
        inr   = (a >= BASE) && ((64'(a) - 64'(BASE)) < 64'(DEPTH * 4));
        algn  = (int'(a[1:0]) % sz) == 0;
        err   = !(legal && inr && algn);
        rd    = 32'd0;
        if (!err && !wen) begin
            rel = int'(a - BASE);
            v = 64'd0;
            for (int i = 0; i < sz; i++) v = v | (64'(mb[rel + i]) << (8 * i));
            if (!f[2] && v[8 * sz - 1]) v = v | (~64'd0 << (8 * sz));
            rd = v[31:0];
        end
    endfunction

    function automatic void model_write(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        int rel;
        rel = int'(a - BASE);
        for (int i = 0; i < size_of(f); i++) mb[rel + i] = wd[8 * i +: 8];
    endfunction

    // Reference timeline state.
    logic        mon_en = 1'b1;
    logic        pending = 1'b0;
    int          acc_edge = 0;
    int          dly = 0;
    logic [31:0] exp_rd = 32'd0;
    logic        exp_err = 1'b0;
    logic        pw_en = 1'b0;
    logic [2:0]  pw_func = 3'd0;
    logic [31:0] pw_addr = 32'd0;
    logic [31:0] pw_data = 32'd0;
    logic [7:0]  lfsr_m = 8'hA5;

    // Compare process: every falling edge, outputs against the reference timeline.
    always @(negedge clk) begin
        logic ev;
        if (mon_en) begin
            ev = pending && (cyc >= acc_edge + dly + 1);
            check1("req_ready", req_ready, !rst && !pending);
            check1("rsp_valid", rsp_valid, ev);
            if (ev) begin
                check32("rsp_rdata", rsp_rdata, exp_rd);
                check1("rsp_err", rsp_err, exp_err);
                if (pw_en) begin
                    model_write(pw_func, pw_addr, pw_data);
                    pw_en = 1'b0;
                end
            end
            if (rst) begin
                pending = 1'b0;
                pw_en   = 1'b0;
                lfsr_m  = 8'hA5;
            end else if (pending) begin
                if (ev && rsp_ready) pending = 1'b0;
            end else if (req_valid) begin
                pending  = 1'b1;
                acc_edge = cyc + 1;
`ifdef YSYX_23060203_MEM_LFSR_DELAY_EN
                dly      = LAT + int'(lfsr_m[1:0]);
                lfsr_m   = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
                dly      = LAT;
`endif
                model_eval(req_wen, req_func, req_addr, exp_rd, exp_err);
                pw_en   = req_wen && !exp_err;
                pw_func = req_func;
                pw_addr = req_addr;
                pw_data = req_wdata;
            end
        end
    end

    task automatic do_req(input logic wen, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic e, output int lat);
        int n;
        req_wen = wen; req_func = f; req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 600) begin @(posedge clk); #1; n++; end
        check1("rsp_arrives", rsp_valid, 1'b1);
        lat = n;
        rd  = rsp_rdata;
        e   = rsp_err;
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 32'($urandom_range(1, 8));
            1:       return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
            2:       return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'h0000_0002;
            3, 4, 5, 6: return BASE + 32'($urandom_range(0, 63));
            default: return BASE + 32'(DEPTH * 4 - 16) + 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;

        repeat (3) @(posedge clk);
        #1;
        check1("reset_req_ready", req_ready, 1'b0);
        check1("reset_rsp_valid", rsp_valid, 1'b0);
        check32("reset_rsp_rdata", rsp_rdata, 32'd0);
        check1("reset_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;
        #1;
        check1("ready_after_reset", req_ready, 1'b1);

        do_req(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 0, rd, e, lat);
        check32("store_latency", 32'(lat), 32'(FIRST_LAT));
        check32("store_rdata", rd, 32'd0);
        check1("store_err", e, 1'b0);
        do_req(1'b0, 3'b010, 32'h8000_0010, 32'd0, 0, rd, e, lat);
        check32("load_word", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 3'b000, 32'h8000_0011, 32'h0000_0080, 0, rd, e, lat);
        do_req(1'b0, 3'b000, 32'h8000_0011, 32'd0, 0, rd, e, lat);
        check32("load_byte_signed", rd, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h8000_0011, 32'd0, 0, rd, e, lat);
        check32("load_byte_unsigned", rd, 32'h0000_0080);
        do_req(1'b0, 3'b010, 32'h8000_0010, 32'd0, 0, rd, e, lat);
        check32("load_merged_word", rd, 32'hDEAD_80EF);

        do_req(1'b0, 3'b010, 32'h8000_0012, 32'd0, 0, rd, e, lat);
        check1("misaligned_err", e, 1'b1);
        check32("misaligned_rdata", rd, 32'd0);
        do_req(1'b1, 3'b001, 32'h7FFF_FFFE, 32'h0000_1234, 0, rd, e, lat);
        check1("below_base_err", e, 1'b1);
        do_req(1'b0, 3'b011, 32'h8000_0010, 32'd0, 0, rd, e, lat);
        check1("illegal_func_err", e, 1'b1);

        do_req(1'b0, 3'b101, 32'h8000_0012, 32'd0, 5, rd, e, lat);
        check32("backpressure_half", rd, 32'h0000_DEAD);
        check1("ready_after_handshake", req_ready, 1'b1);

        do_req(1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 0, rd, e, lat);
        req_wen = 1'b1; req_func = 3'b010; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h8000_0020, 32'd0, 0, rd, e, lat);
        check32("reset_in_wait_kept", rd, 32'hCAFE_F00D);

        for (int w = 0; w < 16; w++)
            do_req(1'b1, 3'b010, BASE + 32'(w * 4), $urandom, 0, rd, e, lat);
        for (int w = DEPTH - 4; w < DEPTH; w++)
            do_req(1'b1, 3'b010, BASE + 32'(w * 4), $urandom, 0, rd, e, lat);

        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            req_wen   = 1'($urandom_range(0, 1));
            req_func  = 3'($urandom_range(0, 7));
            req_addr  = rand_addr();
            req_wdata = $urandom;
            @(posedge clk); #1;
        end

        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_wen   = 1'($urandom_range(0, 1));
            req_func  = 3'($urandom_range(0, 7));
            req_addr  = rand_addr();
            req_wdata = $urandom;
            @(posedge clk); #1;
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
